// File: rtl/top_memory_access_pkg.sv
// Shared definitions for the memory-access stage: widths, decoded-op field layout,
// funct3 codes, FSM state encoding and the alignment rule.
package top_memory_access_pkg;

  localparam int XLEN = 32;
  localparam int OPLEN = 8;

  // Decoded-op field positions.
  localparam int LOAD_BIT = 0;
  localparam int STORE_BIT = 1;
  localparam int MUST_JUMP_BIT = 2;
  localparam int FUNCT3_BIT_L = 3;
  localparam int FUNCT3_BIT_M = 5;

  localparam logic [2:0] FUNCT3_LB = 3'b000;
  localparam logic [2:0] FUNCT3_LH = 3'b001;
  localparam logic [2:0] FUNCT3_LW = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [1:0] size_code, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size_code)
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/top_memory_access_mem_align.sv
// Combinational lane logic: store data replication and byte strobes, load lane
// extraction with sign or zero extension.
module top_memory_access_mem_align
  import top_memory_access_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_byte = load_word[7:0];
    case (addr_lo)
      2'b00:   load_byte = load_word[7:0];
      2'b01:   load_byte = load_word[15:8];
      2'b10:   load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    load_data = load_word;
    case (funct3)
      FUNCT3_LB:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      FUNCT3_LH:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
      FUNCT3_LBU: load_data = {{(XLEN-8){1'b0}}, load_byte};
      FUNCT3_LHU: load_data = {{(XLEN-16){1'b0}}, load_half};
      default:    load_data = load_word;
    endcase
  end

endmodule

// File: rtl/top_memory_access.sv
// Memory-access stage: IDLE/BUSY FSM driving a req/ack data bus, plus the
// write-back latch that feeds the next stage.
module top_memory_access
  import top_memory_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_memory,
  input  logic [OPLEN-1:0]  decoded_op_em,
  input  logic [XLEN-1:0]   alu_out_em,
  input  logic [XLEN-1:0]   rs2data_em,
  input  logic              jump_state_em,
  input  logic [4:0]        rdsel_em,
  input  logic [XLEN-1:0]   curr_pc_em,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic              dbus_ack,
  input  logic [XLEN-1:0]   dbus_rdata,
  output logic [XLEN-1:0]   rd_data_mw,
  output logic [4:0]        rdsel_mw,
  output logic              jump_state_mw,
  output logic [XLEN-1:0]   jump_addr_mw,
  output logic [OPLEN-1:0]  decoded_op_mw,
  output logic              misalign_mw,
  output logic              stall_memory,
  output logic              state_dbg
);

  // Bus handshake: dbus_req rises on entry to BUSY and, together with addr/we/
  // wdata/wstrb, stays constant until the cycle dbus_ack is high; that cycle
  // completes the transfer (rdata sampled) and the FSM returns to IDLE.
  // dbus_ack seen while IDLE has no effect.

  mem_state_e state_q, state_d;

  logic [OPLEN-1:0] op_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rdsel_q;
  logic             jump_q;

  logic [2:0] funct3_em;
  logic       mem_op_em;
  logic       misalign_em;
  logic       is_idle;
  logic       is_busy;
  logic       start_access;
  logic       pass_through;
  logic       finish_access;
  logic       latch_en;

  logic [OPLEN-1:0] src_op;
  logic [XLEN-1:0]  src_alu;
  logic [XLEN-1:0]  src_pc;
  logic [4:0]       src_rdsel;
  logic             src_jump;
  logic             src_misalign;

  logic [XLEN-1:0] align_wdata;
  logic [3:0]      align_wstrb;
  logic [XLEN-1:0] align_load;

  logic [XLEN-1:0] rd_data_d;
  logic [4:0]      rdsel_d;

  assign funct3_em   = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
  assign mem_op_em   = decoded_op_em[LOAD_BIT] | decoded_op_em[STORE_BIT];
  assign misalign_em = mem_op_em & is_misaligned(funct3_em[1:0], alu_out_em[1:0]);

  assign is_idle       = (state_q == ST_IDLE);
  assign is_busy       = (state_q == ST_BUSY);
  assign start_access  = is_idle & phase_memory & mem_op_em & ~misalign_em;
  assign pass_through  = is_idle & phase_memory & ~(mem_op_em & ~misalign_em);
  assign finish_access = is_busy & dbus_ack;
  assign latch_en      = pass_through | finish_access;

  assign stall_memory = start_access | (is_busy & ~dbus_ack);
  assign dbus_req     = is_busy;
  assign state_dbg    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_access) state_d = ST_BUSY;
      ST_BUSY: if (dbus_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // While BUSY the op is taken from the capture registers, so execute may move on.
  always_comb begin
    src_op       = is_busy ? op_q    : decoded_op_em;
    src_alu      = is_busy ? alu_q   : alu_out_em;
    src_pc       = is_busy ? pc_q    : curr_pc_em;
    src_rdsel    = is_busy ? rdsel_q : rdsel_em;
    src_jump     = is_busy ? jump_q  : jump_state_em;
    src_misalign = is_busy ? 1'b0    : misalign_em;
  end

  top_memory_access_mem_align u_mem_align (
    .funct3     (src_op[FUNCT3_BIT_M:FUNCT3_BIT_L]),
    .addr_lo    (src_alu[1:0]),
    .store_data (rs2data_em),
    .load_word  (dbus_rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_data  (align_load)
  );

  always_comb begin
    rd_data_d = src_alu;
    if (src_misalign)                rd_data_d = '0;
    else if (src_op[LOAD_BIT])       rd_data_d = align_load;
    else if (src_op[MUST_JUMP_BIT])  rd_data_d = src_pc + XLEN'(4);
    rdsel_d = (src_misalign | src_op[STORE_BIT]) ? 5'd0 : src_rdsel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
      rdsel_q    <= '0;
      jump_q     <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_wstrb <= '0;
    end else if (start_access) begin
      op_q       <= decoded_op_em;
      alu_q      <= alu_out_em;
      pc_q       <= curr_pc_em;
      rdsel_q    <= rdsel_em;
      jump_q     <= jump_state_em;
      dbus_we    <= decoded_op_em[STORE_BIT];
      dbus_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
      dbus_wdata <= align_wdata;
      dbus_wstrb <= decoded_op_em[STORE_BIT] ? align_wstrb : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_mw    <= '0;
      rdsel_mw      <= '0;
      jump_state_mw <= 1'b0;
      jump_addr_mw  <= '0;
      decoded_op_mw <= '0;
      misalign_mw   <= 1'b0;
    end else if (latch_en) begin
      rd_data_mw    <= rd_data_d;
      rdsel_mw      <= rdsel_d;
      jump_state_mw <= src_jump;
      jump_addr_mw  <= src_alu;
      decoded_op_mw <= src_op;
      misalign_mw   <= src_misalign;
    end
  end

endmodule
